// File: rtl/axil_cmd_pkg.sv
// Shared types and constants for the AXI4-Lite command master:
// FSM state encoding and AXI response codes.
package axil_cmd_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrResp,
        StRdReq,
        StRdResp,
        StRsp
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_cmd_master_if.sv
// Command, response and AXI4-Lite master signals of axil_cmd_master.
// The master modport is the block's own view; slave is the environment's view.
interface axil_cmd_master_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [STRB_WIDTH-1:0] cmd_wstrb;
    logic [2:0]            cmd_prot;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic [1:0]            rsp_resp;
    logic                  rsp_write;
    logic                  rsp_timeout;

    logic [ADDR_WIDTH-1:0] m_axil_awaddr;
    logic [2:0]            m_axil_awprot;
    logic                  m_axil_awvalid;
    logic                  m_axil_awready;
    logic [DATA_WIDTH-1:0] m_axil_wdata;
    logic [STRB_WIDTH-1:0] m_axil_wstrb;
    logic                  m_axil_wvalid;
    logic                  m_axil_wready;
    logic [1:0]            m_axil_bresp;
    logic                  m_axil_bvalid;
    logic                  m_axil_bready;
    logic [ADDR_WIDTH-1:0] m_axil_araddr;
    logic [2:0]            m_axil_arprot;
    logic                  m_axil_arvalid;
    logic                  m_axil_arready;
    logic [DATA_WIDTH-1:0] m_axil_rdata;
    logic [1:0]            m_axil_rresp;
    logic                  m_axil_rvalid;
    logic                  m_axil_rready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_prot,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_resp, rsp_write, rsp_timeout,
        input  rsp_ready,
        output m_axil_awaddr, m_axil_awprot, m_axil_awvalid,
        input  m_axil_awready,
        output m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
        input  m_axil_wready,
        input  m_axil_bresp, m_axil_bvalid,
        output m_axil_bready,
        output m_axil_araddr, m_axil_arprot, m_axil_arvalid,
        input  m_axil_arready,
        input  m_axil_rdata, m_axil_rresp, m_axil_rvalid,
        output m_axil_rready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_prot,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_resp, rsp_write, rsp_timeout,
        output rsp_ready,
        input  m_axil_awaddr, m_axil_awprot, m_axil_awvalid,
        output m_axil_awready,
        input  m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
        output m_axil_wready,
        output m_axil_bresp, m_axil_bvalid,
        input  m_axil_bready,
        input  m_axil_araddr, m_axil_arprot, m_axil_arvalid,
        output m_axil_arready,
        output m_axil_rdata, m_axil_rresp, m_axil_rvalid,
        input  m_axil_rready
    );

endinterface

// File: rtl/axil_cmd_timeout.sv
// Response-wait counter used when AXIL_CMD_MASTER_TIMEOUT_EN is defined.
// Counts cycles spent waiting; expired_o marks the TIMEOUT_CYCLES-th waiting cycle.
module axil_cmd_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic expired_o
);
    localparam int unsigned CntWidth = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntWidth-1:0] Limit = CntWidth'(TIMEOUT_CYCLES - 1);

    logic [CntWidth-1:0] cnt_q, cnt_d;

    // Dropping run_i clears the count, so every wait starts from zero.
    always_comb begin
        cnt_d = '0;
        if (run_i) begin
            cnt_d = cnt_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = run_i & (cnt_q == Limit);

endmodule

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master driven by a simple command/response handshake.
// Define AXIL_CMD_MASTER_TIMEOUT_EN to abort response waits after TIMEOUT_CYCLES cycles.
module axil_cmd_master
    import axil_cmd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic               clk,
    input logic               rst,
    axil_cmd_master_if.master bus
);
    state_e state_q, state_d;

    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic [2:0]            prot_q, prot_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic                  rsp_write_q, rsp_write_d;

    logic cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid;
    logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic tmo_expired, tmo_take;

    assign cmd_hs   = bus.cmd_valid & cmd_ready;
    assign aw_hs    = awvalid & bus.m_axil_awready;
    assign w_hs     = wvalid & bus.m_axil_wready;
    assign b_hs     = bus.m_axil_bvalid & bready;
    assign ar_hs    = arvalid & bus.m_axil_arready;
    assign r_hs     = bus.m_axil_rvalid & rready;
    // A real response in the expiry cycle wins over the timeout.
    assign tmo_take = tmo_expired & ~b_hs & ~r_hs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (cmd_hs) state_d = bus.cmd_write ? StWrReq : StRdReq;
            StWrReq:  if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) state_d = StWrResp;
            StWrResp: if (b_hs | tmo_expired) state_d = StRsp;
            StRdReq:  if (ar_hs) state_d = StRdResp;
            StRdResp: if (r_hs | tmo_expired) state_d = StRsp;
            StRsp:    if (bus.rsp_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            StIdle:   cmd_ready = ~rst;
            StWrReq: begin
                awvalid = ~aw_done_q;
                wvalid  = ~w_done_q;
            end
            StWrResp: bready    = 1'b1;
            StRdReq:  arvalid   = 1'b1;
            StRdResp: rready    = 1'b1;
            StRsp:    rsp_valid = 1'b1;
            default:  ;
        endcase
    end

    always_comb begin
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        prot_d      = prot_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_write_d = rsp_write_q;
        if (cmd_hs) begin
            write_d   = bus.cmd_write;
            addr_d    = bus.cmd_addr;
            wdata_d   = bus.cmd_wdata;
            wstrb_d   = bus.cmd_wstrb;
            prot_d    = bus.cmd_prot;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if (b_hs) begin
            rsp_rdata_d = '0;
            rsp_resp_d  = bus.m_axil_bresp;
            rsp_write_d = 1'b1;
        end else if (r_hs) begin
            rsp_rdata_d = bus.m_axil_rdata;
            rsp_resp_d  = bus.m_axil_rresp;
            rsp_write_d = 1'b0;
        end else if (tmo_take) begin
            rsp_rdata_d = '0;
            rsp_resp_d  = RESP_SLVERR;
            rsp_write_d = write_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            prot_q      <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            rsp_write_q <= 1'b0;
        end else begin
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            prot_q      <= prot_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_write_q <= rsp_write_d;
        end
    end

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    logic rsp_timeout_q, rsp_timeout_d;

    axil_cmd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .run_i    ((state_q == StWrResp) | (state_q == StRdResp)),
        .expired_o(tmo_expired)
    );

    always_comb begin
        rsp_timeout_d = rsp_timeout_q;
        if (cmd_hs) begin
            rsp_timeout_d = 1'b0;
        end else if (tmo_take) begin
            rsp_timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.rsp_timeout = rsp_timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign tmo_expired        = 1'b0;
    assign bus.rsp_timeout    = 1'b0;
`endif

    assign bus.cmd_ready      = cmd_ready;
    assign bus.rsp_valid      = rsp_valid;
    assign bus.rsp_rdata      = rsp_rdata_q;
    assign bus.rsp_resp       = rsp_resp_q;
    assign bus.rsp_write      = rsp_write_q;
    assign bus.m_axil_awaddr  = addr_q;
    assign bus.m_axil_awprot  = prot_q;
    assign bus.m_axil_awvalid = awvalid;
    assign bus.m_axil_wdata   = wdata_q;
    assign bus.m_axil_wstrb   = wstrb_q;
    assign bus.m_axil_wvalid  = wvalid;
    assign bus.m_axil_bready  = bready;
    assign bus.m_axil_araddr  = addr_q;
    assign bus.m_axil_arprot  = prot_q;
    assign bus.m_axil_arvalid = arvalid;
    assign bus.m_axil_rready  = rready;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Scoreboard bench for axil_cmd_master with a latency-programmable AXI4-Lite slave.
// Timeout scenarios run only when AXIL_CMD_MASTER_TIMEOUT_EN is defined.
module tb_axil_cmd_master;
    import axil_cmd_pkg::*;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 32;
    localparam int unsigned SW  = 4;
    localparam int unsigned TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axil_cmd_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) bus ();

    axil_cmd_master #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .STRB_WIDTH    (SW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        write;
        logic        tmo;
    } rsp_t;

    rsp_t sb_q[$];
    rsp_t mon_exp;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave knobs: *_lat is the number of cycles valid is seen before ready/valid is given.
    int aw_lat = 1, w_lat = 1, ar_lat = 1, b_lat = 0, r_lat = 0;
    bit b_never = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] sl_awaddr, sl_wdata, sl_araddr;
    logic [3:0]  sl_wstrb;
    logic [2:0]  sl_awprot;

    logic aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    int   n_bhs = 0;
    int   n_awv = 0, n_wv = 0;

    always @(posedge clk) begin
        aw_hs <= bus.m_axil_awvalid & bus.m_axil_awready;
        w_hs  <= bus.m_axil_wvalid & bus.m_axil_wready;
        b_hs  <= bus.m_axil_bvalid & bus.m_axil_bready;
        ar_hs <= bus.m_axil_arvalid & bus.m_axil_arready;
        r_hs  <= bus.m_axil_rvalid & bus.m_axil_rready;
        if (bus.m_axil_bvalid & bus.m_axil_bready) n_bhs <= n_bhs + 1;
    end

    always @(negedge clk) begin
        if (bus.m_axil_awvalid) n_awv++;
        if (bus.m_axil_wvalid) n_wv++;
    end

    int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
    bit got_aw = 0, got_w = 0, got_ar = 0;

    always @(negedge clk) begin
        logic [31:0] word;
        if (rst) begin
            bus.m_axil_awready = 0; bus.m_axil_wready = 0; bus.m_axil_arready = 0;
            bus.m_axil_bvalid = 0; bus.m_axil_rvalid = 0;
            got_aw = 0; got_w = 0; got_ar = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        end else begin
            if (b_hs) begin
                got_aw = 0; got_w = 0; bus.m_axil_bvalid = 0; b_wait = 0;
            end
            if (r_hs) begin
                got_ar = 0; bus.m_axil_rvalid = 0; r_wait = 0;
            end
            if (aw_hs) begin
                got_aw = 1; sl_awaddr = bus.m_axil_awaddr; sl_awprot = bus.m_axil_awprot;
            end
            if (w_hs) begin
                got_w = 1; sl_wdata = bus.m_axil_wdata; sl_wstrb = bus.m_axil_wstrb;
            end
            if (ar_hs) begin
                got_ar = 1; sl_araddr = bus.m_axil_araddr;
            end
            bus.m_axil_awready = 0;
            if (bus.m_axil_awvalid) begin
                if (aw_wait == aw_lat - 1) bus.m_axil_awready = 1;
                else aw_wait++;
            end else aw_wait = 0;
            bus.m_axil_wready = 0;
            if (bus.m_axil_wvalid) begin
                if (w_wait == w_lat - 1) bus.m_axil_wready = 1;
                else w_wait++;
            end else w_wait = 0;
            bus.m_axil_arready = 0;
            if (bus.m_axil_arvalid) begin
                if (ar_wait == ar_lat - 1) bus.m_axil_arready = 1;
                else ar_wait++;
            end else ar_wait = 0;
            if (got_aw && got_w && !bus.m_axil_bvalid && !b_never) begin
                if (b_wait == b_lat) begin
                    word = mem.exists(sl_awaddr) ? mem[sl_awaddr] : 32'h0;
                    for (int b = 0; b < 4; b++)
                        if (sl_wstrb[b]) word[8*b +: 8] = sl_wdata[8*b +: 8];
                    mem[sl_awaddr] = word;
                    bus.m_axil_bvalid = 1;
                    bus.m_axil_bresp  = RESP_OKAY;
                end else b_wait++;
            end
            if (got_ar && !bus.m_axil_rvalid) begin
                if (r_wait == r_lat) begin
                    bus.m_axil_rvalid = 1;
                    bus.m_axil_rresp  = RESP_OKAY;
                    bus.m_axil_rdata  = mem.exists(sl_araddr) ? mem[sl_araddr] : 32'h0;
                end else r_wait++;
            end
        end
    end

    // Monitor: every response handshake is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (sb_q.size() == 0) begin
                check("rsp_unexpected_qsize", 64'(sb_q.size()), 64'd1);
            end else begin
                mon_exp = sb_q.pop_front();
                check("rsp_rdata", bus.rsp_rdata, mon_exp.rdata);
                check("rsp_resp", bus.rsp_resp, mon_exp.resp);
                check("rsp_write", bus.rsp_write, mon_exp.write);
                check("rsp_timeout", bus.rsp_timeout, mon_exp.tmo);
            end
        end
    end

    task automatic push(input logic [31:0] d, input logic [1:0] r, input logic w, input logic t);
        rsp_t e;
        e.rdata = d; e.resp = r; e.write = w; e.tmo = t;
        sb_q.push_back(e);
    endtask

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p);
        @(posedge clk); #1;
        bus.cmd_valid = 1; bus.cmd_write = wr; bus.cmd_addr = a;
        bus.cmd_wdata = d; bus.cmd_wstrb = s; bus.cmd_prot = p;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) break;
        end
        check("cmd_accept", bus.cmd_ready, 1);
        @(posedge clk); #1;
        // Scramble the inputs: the accepted command must already be registered.
        bus.cmd_valid = 0; bus.cmd_write = ~wr; bus.cmd_addr = ~a;
        bus.cmd_wdata = ~d; bus.cmd_wstrb = ~s; bus.cmd_prot = ~p;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            cyc++;
            if (bus.rsp_valid) break;
        end
        check("rsp_seen", bus.rsp_valid, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
        check("sb_drain", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        @(posedge clk); #1 rst = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, na, nw, nb;
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0; bus.cmd_wdata = 0;
        bus.cmd_wstrb = 0; bus.cmd_prot = 0; bus.rsp_ready = 1;
        bus.m_axil_awready = 0; bus.m_axil_wready = 0; bus.m_axil_arready = 0;
        bus.m_axil_bvalid = 0; bus.m_axil_bresp = 0; bus.m_axil_rvalid = 0;
        bus.m_axil_rdata = 0; bus.m_axil_rresp = 0;

        repeat (2) @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_axi_valids", {bus.m_axil_awvalid, bus.m_axil_wvalid, bus.m_axil_arvalid,
                                 bus.m_axil_bready, bus.m_axil_rready}, 5'b0);
        check("rst_rsp_payload", {bus.rsp_rdata, bus.rsp_resp, bus.rsp_write, bus.rsp_timeout},
              36'h0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check("cmd_ready_after_rst", bus.cmd_ready, 1);

        // Write then read back.
        push(32'h0, RESP_OKAY, 1, 0);
        issue(1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b010);
        wait_rsp(cyc); drain();
        check("wr_awaddr", sl_awaddr, 32'h10);
        check("wr_awprot", sl_awprot, 3'b010);
        check("wr_wdata", sl_wdata, 32'hDEADBEEF);
        push(32'hDEADBEEF, RESP_OKAY, 0, 0);
        issue(0, 32'h10, 32'h0, 4'h0, 3'b000);
        wait_rsp(cyc); drain();
        check("rd_araddr", sl_araddr, 32'h10);

        // Slow awready, immediate wready, partial strobe.
        aw_lat = 3;
        na = n_awv; nw = n_wv; nb = n_bhs;
        push(32'h0, RESP_OKAY, 1, 0);
        issue(1, 32'h20, 32'h12345678, 4'h3, 3'b000);
        wait_rsp(cyc); drain();
        check("awvalid_cycles", n_awv - na, 3);
        check("wvalid_cycles", n_wv - nw, 1);
        check("b_handshakes", n_bhs - nb, 1);
        check("slow_aw_addr", sl_awaddr, 32'h20);
        aw_lat = 1;
        push(32'h00005678, RESP_OKAY, 0, 0);
        issue(0, 32'h20, 32'h0, 4'h0, 3'b000);
        wait_rsp(cyc); drain();

        // Response held off by rsp_ready.
        bus.rsp_ready = 0;
        push(32'hDEADBEEF, RESP_OKAY, 0, 0);
        issue(0, 32'h10, 32'h0, 4'h0, 3'b000);
        wait_rsp(cyc);
        for (int i = 0; i < 5; i++) begin
            check("hold_rsp_valid", bus.rsp_valid, 1);
            check("hold_rsp_rdata", bus.rsp_rdata, 32'hDEADBEEF);
            check("hold_rsp_write", bus.rsp_write, 0);
            check("hold_cmd_ready", bus.cmd_ready, 0);
            if (i < 4) @(negedge clk);
        end
        @(posedge clk); #1 bus.rsp_ready = 1;
        @(negedge clk);
        check("rsp_hs_cmd_ready", bus.cmd_ready, 0);
        @(negedge clk);
        check("post_rsp_cmd_ready", bus.cmd_ready, 1);
        drain();

        // Reset while arvalid waits on a stalled arready.
        ar_lat = 1000;
        issue(0, 32'h10, 32'h0, 4'h0, 3'b000);
        for (int i = 0; i < 20 && !bus.m_axil_arvalid; i++) @(negedge clk);
        check("arvalid_before_rst", bus.m_axil_arvalid, 1);
        rst = 1; #1;
        check("arvalid_in_rst", bus.m_axil_arvalid, 0);
        check("cmd_ready_in_rst", bus.cmd_ready, 0);
        check("rsp_rdata_in_rst", bus.rsp_rdata, 32'h0);
        @(posedge clk); #1 rst = 0;
        ar_lat = 1;
        @(negedge clk);
        check("cmd_ready_after_midrst", bus.cmd_ready, 1);
        push(32'hDEADBEEF, RESP_OKAY, 0, 0);
        issue(0, 32'h10, 32'h0, 4'h0, 3'b000);
        wait_rsp(cyc); drain();

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
        b_never = 1;
        push(32'h0, RESP_SLVERR, 1, 1);
        issue(1, 32'h30, 32'hA5A5A5A5, 4'hF, 3'b000);
        wait_rsp(cyc);
        check("wr_tmo_cycles", cyc, 10);
        check("wr_tmo_bready", bus.m_axil_bready, 0);
        drain();
        b_never = 0;
        pulse_rst();

        r_lat = 7;
        push(32'hDEADBEEF, RESP_OKAY, 0, 0);
        issue(0, 32'h10, 32'h0, 4'h0, 3'b000);
        wait_rsp(cyc);
        check("rd_edge_cycles", cyc, 10);
        drain();

        r_lat = 8;
        push(32'h0, RESP_SLVERR, 0, 1);
        issue(0, 32'h10, 32'h0, 4'h0, 3'b000);
        wait_rsp(cyc);
        check("rd_tmo_cycles", cyc, 10);
        check("rd_tmo_rready", bus.m_axil_rready, 0);
        drain();
        r_lat = 0;
        pulse_rst();
`else
        b_lat = 20;
        push(32'h0, RESP_OKAY, 1, 0);
        issue(1, 32'h30, 32'hA5A5A5A5, 4'hF, 3'b000);
        wait_rsp(cyc);
        check("slow_b_cycles", cyc, 23);
        drain();
        b_lat = 0;
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
